// File: rtl/song_player_ctrl.sv
// Transport controller for the song progression timer: turns button and
// end-of-song pulses into play / clear / done controls and the song index.
module song_player_ctrl #(
    parameter int                NUM_SONGS    = 4,
    parameter int                SONG_W       = 2,
    parameter int                HOLD_W       = 26,
    parameter logic [HOLD_W-1:0] DONE_HOLD    = 26'd50000000,
    parameter logic              AUTO_ADVANCE = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              play_button,
    input  logic              next_button,
    input  logic              song_end,
    output logic              play,
    output logic              reset_player,
    output logic              song_done,
    output logic [SONG_W-1:0] current_song,
    output logic [1:0]        state
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PLAYING = 2'd1,
        PAUSED  = 2'd2,
        DONE    = 2'd3
    } state_t;

    localparam logic [SONG_W-1:0] LAST_SONG = SONG_W'(NUM_SONGS - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = DONE_HOLD - 1'b1;

    state_t            state_q;
    logic [HOLD_W-1:0] hold_cnt;
    logic [SONG_W-1:0] next_song;

    assign next_song = (current_song == LAST_SONG) ? '0 : current_song + 1'b1;
    assign play      = (state_q == PLAYING);
    assign state     = state_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            current_song <= '0;
            hold_cnt     <= '0;
            reset_player <= 1'b0;
            song_done    <= 1'b0;
        end else begin
            reset_player <= 1'b0;
            song_done    <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (next_button) begin
                        current_song <= next_song;
                        reset_player <= 1'b1;
                    end else if (play_button) begin
                        state_q <= PLAYING;
                    end
                end
                PLAYING: begin
                    if (song_end) begin
                        state_q   <= DONE;
                        song_done <= 1'b1;
                        hold_cnt  <= '0;
                    end else if (next_button) begin
                        state_q      <= IDLE;
                        current_song <= next_song;
                        reset_player <= 1'b1;
                    end else if (play_button) begin
                        state_q <= PAUSED;
                    end
                end
                PAUSED: begin
                    if (next_button) begin
                        state_q      <= IDLE;
                        current_song <= next_song;
                        reset_player <= 1'b1;
                    end else if (play_button) begin
                        state_q <= PLAYING;
                    end
                end
                DONE: begin
                    // Skip aborts the hold; otherwise leave once it expires
                    if (next_button) begin
                        state_q      <= IDLE;
                        current_song <= next_song;
                        reset_player <= 1'b1;
                        hold_cnt     <= '0;
                    end else if (hold_cnt == HOLD_LAST) begin
                        state_q      <= IDLE;
                        reset_player <= 1'b1;
                        hold_cnt     <= '0;
                        if (AUTO_ADVANCE) begin
                            current_song <= next_song;
                        end
                    end else begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end
                end
                default: begin
                    state_q  <= IDLE;
                    hold_cnt <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_song_player_ctrl.sv
// Randomised bench for song_player_ctrl: two parameterisations driven in
// lockstep and compared each cycle with a behavioural transport model.
module tb_song_player_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic play_button = 1'b0;
    logic next_button = 1'b0;
    logic song_end = 1'b0;

    logic       a_play, a_rp, a_sd;
    logic [1:0] a_song, a_state;
    logic       b_play, b_rp, b_sd;
    logic [1:0] b_song, b_state;

    int n_checks = 0;
    int n_fails  = 0;

    always #5 clk = ~clk;

    song_player_ctrl #(
        .NUM_SONGS(3), .SONG_W(2), .HOLD_W(4),
        .DONE_HOLD(4'd8), .AUTO_ADVANCE(1'b1)
    ) dut_a (
        .clk(clk), .rst(rst),
        .play_button(play_button), .next_button(next_button),
        .song_end(song_end),
        .play(a_play), .reset_player(a_rp), .song_done(a_sd),
        .current_song(a_song), .state(a_state)
    );

    song_player_ctrl #(
        .NUM_SONGS(4), .SONG_W(2), .HOLD_W(3),
        .DONE_HOLD(3'd5), .AUTO_ADVANCE(1'b0)
    ) dut_b (
        .clk(clk), .rst(rst),
        .play_button(play_button), .next_button(next_button),
        .song_end(song_end),
        .play(b_play), .reset_player(b_rp), .song_done(b_sd),
        .current_song(b_song), .state(b_state)
    );

    // Model: 0 idle, 1 playing, 2 paused, 3 done; dwell = cycles spent in done
    int n_songs [2] = '{3, 4};
    int hold    [2] = '{8, 5};
    int auto_adv[2] = '{1, 0};
    int m_st    [2] = '{0, 0};
    int m_song  [2] = '{0, 0};
    int m_dwell [2] = '{0, 0};
    int m_rp    [2] = '{0, 0};
    int m_sd    [2] = '{0, 0};

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_step(input int i, input bit r, input bit pb,
                              input bit nb, input bit se);
        int adv;
        adv = (m_song[i] + 1) % n_songs[i];
        m_rp[i] = 0;
        m_sd[i] = 0;
        if (r) begin
            m_st[i] = 0;
            m_song[i] = 0;
            m_dwell[i] = 0;
            return;
        end
        case (m_st[i])
            0: if (nb) begin
                m_song[i] = adv; m_rp[i] = 1;
            end else if (pb) m_st[i] = 1;
            1: if (se) begin
                m_st[i] = 3; m_sd[i] = 1; m_dwell[i] = 0;
            end else if (nb) begin
                m_st[i] = 0; m_song[i] = adv; m_rp[i] = 1;
            end else if (pb) m_st[i] = 2;
            2: if (nb) begin
                m_st[i] = 0; m_song[i] = adv; m_rp[i] = 1;
            end else if (pb) m_st[i] = 1;
            default: begin
                m_dwell[i]++;
                if (nb) begin
                    m_st[i] = 0; m_song[i] = adv; m_rp[i] = 1;
                end else if (m_dwell[i] == hold[i]) begin
                    m_st[i] = 0; m_rp[i] = 1;
                    if (auto_adv[i] != 0) m_song[i] = adv;
                end
            end
        endcase
    endtask

    task automatic compare_all();
        check("a_state", int'(a_state), m_st[0]);
        check("a_play",  int'(a_play),  int'(m_st[0] == 1));
        check("a_rp",    int'(a_rp),    m_rp[0]);
        check("a_sd",    int'(a_sd),    m_sd[0]);
        check("a_song",  int'(a_song),  m_song[0]);
        check("b_state", int'(b_state), m_st[1]);
        check("b_play",  int'(b_play),  int'(m_st[1] == 1));
        check("b_rp",    int'(b_rp),    m_rp[1]);
        check("b_sd",    int'(b_sd),    m_sd[1]);
        check("b_song",  int'(b_song),  m_song[1]);
    endtask

    task automatic cyc(input bit r, input bit pb, input bit nb, input bit se);
        @(negedge clk);
        rst = r;
        play_button = pb;
        next_button = nb;
        song_end = se;
        model_step(0, r, pb, nb, se);
        model_step(1, r, pb, nb, se);
        @(posedge clk);
        #1;
        compare_all();
    endtask

    initial begin
        // reset, then start playing
        repeat (3) cyc(1, 0, 0, 0);
        check("rst_state", int'(a_state), 0);
        check("rst_song",  int'(a_song), 0);
        cyc(0, 0, 0, 0);
        cyc(0, 1, 0, 0);
        check("play_starts", int'(a_play), 1);
        // pause / resume, then play+next together
        cyc(0, 1, 0, 0);
        cyc(0, 1, 0, 0);
        cyc(0, 1, 1, 0);
        check("skip_song", int'(a_song), 1);
        // natural end and hold timeout
        cyc(0, 1, 0, 0);
        cyc(0, 0, 0, 1);
        check("done_pulse", int'(a_sd), 1);
        repeat (8) cyc(0, 0, 0, 0);
        check("hold_exit_rp", int'(a_rp), 1);
        check("hold_exit_song", int'(a_song), 2);
        cyc(0, 0, 0, 0);
        // song_end beats next_button; song_end ignored while paused
        cyc(0, 1, 0, 0);
        cyc(0, 0, 1, 1);
        check("end_wins_rp", int'(a_rp), 0);
        repeat (9) cyc(0, 0, 0, 0);
        cyc(0, 1, 0, 0);
        cyc(0, 1, 0, 0);
        cyc(0, 0, 0, 1);
        check("paused_ignores_end", int'(a_state), 2);
        // wrap through all songs from idle
        cyc(0, 0, 1, 0);
        repeat (3) cyc(0, 0, 1, 0);
        // reset during hold and during play
        cyc(0, 1, 0, 0);
        cyc(0, 0, 0, 1);
        repeat (3) cyc(0, 0, 0, 0);
        cyc(1, 0, 0, 0);
        check("rst_in_done", int'(a_state), 0);
        cyc(0, 1, 0, 0);
        cyc(1, 0, 0, 0);
        check("rst_in_play", int'(a_play), 0);
        // random traffic
        for (int k = 0; k < 4000; k++) begin
            cyc(($urandom_range(99) < 1),
                ($urandom_range(99) < 20),
                ($urandom_range(99) < 6),
                ($urandom_range(99) < 15));
        end
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fails);
        $finish;
    end

endmodule
